// File: rtl/spi_device.sv
// SPI device (target) with a one-byte TX holding buffer. All SPI pins are sampled
// into the clk_i domain, and every protocol action runs from the synchronized edges.
module spi_device #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic       spi_rx_i,
  output logic       spi_tx_o,
  output logic       spi_tx_en_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       tx_underrun_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // The sample edge is the rising edge of SCK when CPOL == CPHA.
  localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);

  state_e      state_q, state_d;
  logic [2:0]  sck_q;
  logic [2:0]  cs_q;
  logic [1:0]  mosi_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  tx_shift_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic        byte_done_q;

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic sample_edge, shift_edge;
  logic active, enter, leave, run;
  logic do_sample, do_shift, load, hold_wr, byte_end;

  // Stage 0 meets metastability, stage 1 is the synchronized value, and stage 2
  // is its previous value for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_q  <= {3{CPOL}};
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, which is what forms the synchronizer chain.
      sck_q  <= {sck_q[1:0], spi_sck_i};
      cs_q   <= {cs_q[1:0], spi_cs_ni};
      mosi_q <= {mosi_q[0], spi_rx_i};
    end
  end

  assign sck_rise    = sck_q[1] & ~sck_q[2];
  assign sck_fall    = ~sck_q[1] & sck_q[2];
  assign cs_fall     = ~cs_q[1] & cs_q[2];
  assign cs_rise     = cs_q[1] & ~cs_q[2];
  assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: assigning the default first means every path drives state_d, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign active = (state_q == ACTIVE);
  assign enter  = (state_q == IDLE) && cs_fall;
  assign leave  = active && cs_rise;
  // CS release takes priority over any SCK edge seen in the same cycle.
  assign run    = active && !cs_rise;

  assign do_sample = run && sample_edge;
  assign byte_end  = do_sample && (bit_cnt_q == 3'd7);
  assign load      = CPHA ? (run && shift_edge && (bit_cnt_q == 3'd0))
                          : (enter || (run && shift_edge && byte_done_q));
  assign do_shift  = run && shift_edge && !load;
  assign hold_wr   = tx_valid_i && !hold_full_q;

  // A write only happens while the buffer is empty, so a load in the same cycle
  // finds it empty and underruns while the new byte stays in the buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q        <= 8'h00;
      hold_full_q   <= 1'b0;
      tx_shift_q    <= 8'h00;
      tx_underrun_o <= 1'b0;
    end else begin
      tx_underrun_o <= load && !hold_full_q;
      if (hold_wr) begin
        hold_q      <= tx_byte_i;
        hold_full_q <= 1'b1;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end
      if (load)          tx_shift_q <= hold_full_q ? hold_q : 8'hFF;
      else if (do_shift) tx_shift_q <= {tx_shift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      byte_done_q <= 1'b0;
      rx_byte_o   <= 8'h00;
      rx_valid_o  <= 1'b0;
    end else begin
      rx_valid_o <= byte_end;
      if (byte_end) rx_byte_o <= {rx_shift_q[6:0], mosi_q[1]};
      if (leave || enter) begin
        bit_cnt_q   <= 3'd0;
        rx_shift_q  <= 8'h00;
        byte_done_q <= 1'b0;
      end else begin
        if (do_sample) begin
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          rx_shift_q <= {rx_shift_q[6:0], mosi_q[1]};
        end
        // Marks the first shift edge of the next byte as a load point.
        if (byte_end)  byte_done_q <= 1'b1;
        else if (load) byte_done_q <= 1'b0;
      end
    end
  end

  assign spi_tx_o    = active ? tx_shift_q[7] : 1'b1;
  assign spi_tx_en_o = active;
  assign tx_ready_o  = !hold_full_q;

endmodule

// File: tb/tb_spi_device.sv
// Self-checking bench for spi_device: one instance per SPI mode, driven by a
// behavioural host and checked against a transaction-level buffer model.
`timescale 1ns/1ps
module tb_spi_device;

  logic       clk;
  logic       rst_n;
  logic       mosi;
  logic [7:0] tx_byte;
  logic       sck      [4];
  logic       cs_n     [4];
  logic       tx_valid [4];
  logic       miso     [4];
  logic       miso_en  [4];
  logic       ready    [4];
  logic       rx_valid [4];
  logic       ur       [4];
  logic [7:0] rx_byte  [4];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  bit         hold_v      [4];
  logic [7:0] hold_d      [4];
  int         exp_rx      [4];
  int         exp_ur      [4];
  logic [7:0] exp_rx_byte [4];
  int         rx_cnt      [4];
  int         ur_cnt      [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_device #(
      .CPOL((g / 2) == 1),
      .CPHA((g % 2) == 1)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .spi_sck_i    (sck[g]),
      .spi_cs_ni    (cs_n[g]),
      .spi_rx_i     (mosi),
      .spi_tx_o     (miso[g]),
      .spi_tx_en_o  (miso_en[g]),
      .tx_byte_i    (tx_byte),
      .tx_valid_i   (tx_valid[g]),
      .tx_ready_o   (ready[g]),
      .rx_byte_o    (rx_byte[g]),
      .rx_valid_o   (rx_valid[g]),
      .tx_underrun_o(ur[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every cycle a pulse output is high, so a stretched pulse shows up.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rx_valid[g] === 1'b1) rx_cnt[g]++;
      if (ur[g] === 1'b1)       ur_cnt[g]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // A load consumes the holding byte, or returns FF and counts an underrun.
  function automatic logic [7:0] mdl_load(input int m);
    if (hold_v[m]) begin
      hold_v[m] = 1'b0;
      return hold_d[m];
    end
    exp_ur[m]++;
    return 8'hFF;
  endfunction

  task automatic mdl_reset();
    for (int g = 0; g < 4; g++) begin
      hold_v[g]      = 1'b0;
      hold_d[g]      = 8'h00;
      exp_rx_byte[g] = 8'h00;
    end
  endtask

  task automatic check_reset_outputs(input int g);
    check("rst_tx",       miso[g],     1);
    check("rst_tx_en",    miso_en[g],  0);
    check("rst_ready",    ready[g],    1);
    check("rst_rx_byte",  rx_byte[g],  0);
    check("rst_rx_valid", rx_valid[g], 0);
    check("rst_underrun", ur[g],       0);
  endtask

  // One-cycle offer on tx_valid; called on a falling clk edge.
  task automatic hb_drive(input int m, input logic [7:0] d);
    check("ready_before_write", ready[m], !hold_v[m]);
    tx_byte     = d;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
    if (!hold_v[m]) begin
      hold_v[m] = 1'b1;
      hold_d[m] = d;
    end
  endtask

  // Host side of nbits SCK cycles, MSB first, half period 4 clk.
  task automatic host_bits(input int m, input logic [7:0] d, input int nbits,
                           input bit do_wr, input logic [7:0] wd, output logic [7:0] rd);
    bit cpol, cpha;
    cpol = (m / 2) == 1;
    cpha = (m % 2) == 1;
    rd = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = 7 - k;
      if (!cpha) begin
        mosi = d[i];
        repeat (4) @(negedge clk);
        rd[i] = miso[m];
        sck[m] = ~cpol;
      end else begin
        sck[m] = ~cpol;
        mosi = d[i];
        repeat (4) @(negedge clk);
        rd[i] = miso[m];
        sck[m] = cpol;
      end
      if (do_wr && k == 4) begin
        hb_drive(m, wd);
        repeat (3) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      if (!cpha) sck[m] = cpol;
    end
  endtask

  task automatic check_idle(input int m);
    check("rx_byte",    rx_byte[m], exp_rx_byte[m]);
    check("rx_pulses",  rx_cnt[m],  exp_rx[m]);
    check("underruns",  ur_cnt[m],  exp_ur[m]);
    check("ready_idle", ready[m],   !hold_v[m]);
    check("tx_en_idle", miso_en[m], 0);
    check("tx_idle",    miso[m],    1);
  endtask

  // Full transfer of nbytes bytes; byte b sits at mo[15-8*b -: 8].
  task automatic xfer(input int m, input int nbytes, input logic [15:0] mo,
                      input logic [1:0] wr, input logic [15:0] wd,
                      output logic [15:0] mi, output logic [15:0] em);
    bit cpha;
    logic [7:0] l, rd;
    cpha = (m % 2) == 1;
    mi = 16'h0;
    em = 16'h0;
    cs_n[m] = 1'b0;
    repeat (4) @(negedge clk);
    check("tx_en_active", miso_en[m], 1);
    if (!cpha) l = mdl_load(m);
    for (int b = 0; b < nbytes; b++) begin
      if (cpha) l = mdl_load(m);
      em[15-8*b -: 8] = l;
      host_bits(m, mo[15-8*b -: 8], 8, wr[1-b], wd[15-8*b -: 8], rd);
      mi[15-8*b -: 8] = rd;
      exp_rx[m]++;
      exp_rx_byte[m] = mo[15-8*b -: 8];
      if (!cpha) l = mdl_load(m);
    end
    repeat (4) @(negedge clk);
    cs_n[m] = 1'b1;
    repeat (8) @(negedge clk);
    check_idle(m);
  endtask

  logic [15:0] mi, em;
  logic [7:0]  r0, r1, w0, w1, rd;
  logic [7:0]  l;
  bit          cpol, cpha;

  initial begin
    rst_n   = 1'b0;
    mosi    = 1'b0;
    tx_byte = 8'h00;
    for (int g = 0; g < 4; g++) begin
      sck[g]      = (g / 2) == 1;
      cs_n[g]     = 1'b1;
      tx_valid[g] = 1'b0;
      exp_rx[g]   = 0;
      exp_ur[g]   = 0;
      rx_cnt[g]   = 0;
      ur_cnt[g]   = 0;
    end
    mdl_reset();
    #1;
    for (int g = 0; g < 4; g++) check_reset_outputs(g);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      cpol = (m / 2) == 1;
      cpha = (m % 2) == 1;

      // SCK activity with CS high must leave no trace.
      for (int k = 0; k < 8; k++) begin
        sck[m] = ~sck[m];
        mosi   = k[0];
        repeat (4) @(negedge clk);
      end
      check("idle_sck_rx",    rx_cnt[m],  exp_rx[m]);
      check("idle_sck_tx_en", miso_en[m], 0);

      // Preloaded A5 out, 3C in.
      hb_drive(m, 8'hA5);
      xfer(m, 1, {8'h3C, 8'h00}, 2'b00, 16'h0, mi, em);
      check("miso_a5", mi[15:8], em[15:8]);

      // Back-to-back 11 then 22; the refill during the last byte covers the
      // CPHA=0 load that follows the final shift edge.
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      w1 = 8'($urandom_range(0, 255));
      hb_drive(m, 8'h11);
      xfer(m, 2, {r0, r1}, {1'b1, !cpha}, {8'h22, w1}, mi, em);
      check("miso_b2b_0", mi[15:8], em[15:8]);
      check("miso_b2b_1", mi[7:0],  em[7:0]);

      // Empty buffer at CS fall.
      check("ready_empty", ready[m], 1);
      r0 = 8'($urandom_range(0, 255));
      w0 = 8'($urandom_range(0, 255));
      xfer(m, 1, {r0, 8'h00}, {!cpha, 1'b0}, {w0, 8'h00}, mi, em);
      check("miso_underrun", mi[15:8], em[15:8]);

      // Abort after 5 bits, then a clean transfer.
      r0 = 8'($urandom_range(0, 255));
      cs_n[m] = 1'b0;
      repeat (4) @(negedge clk);
      l = mdl_load(m);
      host_bits(m, r0, 5, 1'b0, 8'h00, rd);
      check("miso_partial", rd[7:3], l[7:3]);
      repeat (4) @(negedge clk);
      cs_n[m] = 1'b1;
      repeat (8) @(negedge clk);
      check_idle(m);
      r0 = 8'($urandom_range(0, 255));
      w0 = 8'($urandom_range(0, 255));
      hb_drive(m, w0);
      xfer(m, 1, {r0, 8'h00}, 2'b00, 16'h0, mi, em);
      check("miso_after_abort", mi[15:8], em[15:8]);

      // Reset pulse mid-byte, then a clean transfer.
      hb_drive(m, 8'h5A);
      cs_n[m] = 1'b0;
      repeat (4) @(negedge clk);
      if (!cpha) l = mdl_load(m);
      host_bits(m, 8'hC3, 4, 1'b0, 8'h00, rd);
      rst_n = 1'b0;
      #1;
      check_reset_outputs(m);
      mdl_reset();
      cs_n[m] = 1'b1;
      sck[m]  = cpol;
      mosi    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_idle(m);
      r0 = 8'($urandom_range(0, 255));
      w0 = 8'($urandom_range(0, 255));
      hb_drive(m, w0);
      xfer(m, 1, {r0, 8'h00}, 2'b00, 16'h0, mi, em);
      check("miso_after_reset", mi[15:8], em[15:8]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_device.md
SPI_DEVICE -- requirements
Module: spi_device

Interface
REQ-001 Parameter CPOL, default 0: SCK idle level.
REQ-002 Parameter CPHA, default 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
REQ-003 clk_i  input  1  system clock; one clock domain only.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 spi_sck_i  input  1  SPI clock from the host, asynchronous to clk_i.
REQ-006 spi_cs_ni  input  1  chip select, active-low, asynchronous.
REQ-007 spi_rx_i  input  1  MOSI, asynchronous.
REQ-008 spi_tx_o  output  1  MISO data.
REQ-009 spi_tx_en_o  output  1  MISO output enable; high while selected.
REQ-010 tx_byte_i  input  8  next byte to return to the host.
REQ-011 tx_valid_i  input  1  tx_byte_i is valid.
REQ-012 tx_ready_o  output  1  one-byte TX holding buffer is empty; transfer occurs when tx_valid_i and tx_ready_o are both high.
REQ-013 rx_byte_o  output  8  last complete received byte, MSB first.
REQ-014 rx_valid_o  output  1  one-cycle pulse when rx_byte_o updates.
REQ-015 tx_underrun_o  output  1  one-cycle pulse when a byte load finds the holding buffer empty.

Function
REQ-016 spi_sck_i, spi_cs_ni and spi_rx_i SHALL each pass through a 2-flop synchronizer; SCK and CS SHALL have a third stage for edge detection.
REQ-017 Sample edge SHALL be the rising edge of synchronized SCK when CPOL==CPHA, otherwise the falling edge; the shift edge SHALL be the opposite edge.
REQ-018 Supported SCK period SHALL be at least 8 clk_i cycles, with CS setup and hold of at least 4 clk_i cycles around the first and last SCK edges; faster SCK is unsupported.
REQ-019 State machine SHALL be IDLE -> ACTIVE on synchronized CS falling edge, and ACTIVE -> IDLE on synchronized CS rising edge; no other transitions.
REQ-020 In ACTIVE, each sample edge SHALL shift synchronized MOSI into the LSB of the RX shift register and increment a 3-bit bit counter, which wraps 7->0.
REQ-021 On the sample edge that wraps the counter from 7 to 0, the block SHALL copy the full shifted byte to rx_byte_o and pulse rx_valid_o on the following cycle.
REQ-022 spi_tx_o SHALL equal TX shift register bit 7 in ACTIVE and SHALL be 1 in IDLE; spi_tx_en_o SHALL be 1 exactly in ACTIVE.
REQ-023 CPHA=0: the TX shift register SHALL load on entry to ACTIVE, and on the first shift edge after each byte completes; every other shift edge shifts it left and inserts 0.
REQ-024 CPHA=1: the TX shift register SHALL load on the shift edge when the bit counter is 0, and shift left on the remaining shift edges.
REQ-025 A load SHALL take the holding buffer and set tx_ready_o; if the buffer is empty, the block SHALL load 8'hFF and pulse tx_underrun_o.
REQ-026 If a load and a tx_valid_i&&tx_ready_o transfer fall in the same cycle, the incoming byte SHALL go into the holding buffer, not into the shift register.
REQ-027 If CS deasserts mid-byte, the partial RX byte SHALL be discarded with no rx_valid_o, the bit counter SHALL clear, and the holding buffer SHALL be untouched.
REQ-028 SCK edges while in IDLE SHALL be ignored.

Reset
REQ-029 While rst_ni is low: state IDLE; bit counter 0; shift registers 0; holding buffer empty.
REQ-030 Output values during reset: tx_ready_o=1, spi_tx_o=1, spi_tx_en_o=0, rx_byte_o=8'h00, rx_valid_o=0, tx_underrun_o=0; synchronizer flops reset to CPOL / 1 / 0 for SCK / CS / MOSI.
REQ-031 Reset asserted mid-transfer SHALL abort immediately; after release, the block SHALL wait for a fresh CS falling edge.

Verification
REQ-032 Mode 0, SCK period 8 clk: preload 8'hA5, host sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_byte_o=8'h3C with exactly one rx_valid_o pulse.
REQ-033 Repeat REQ-032 for modes 1, 2 and 3 -> identical bytes in both directions.
REQ-034 Two back-to-back bytes without CS deassertion; 8'h11 then 8'h22 written in time -> MISO 8'h11 then 8'h22; two rx_valid_o pulses; no underrun.
REQ-035 Holding buffer empty at CS fall -> MISO 8'hFF; one tx_underrun_o pulse.
REQ-036 CS deasserted after 5 bits -> no rx_valid_o; the next full transfer receives its byte correctly.
REQ-037 rst_ni pulsed low mid-byte -> all outputs at reset values within 1 cycle; the next transfer is correct.
